// File: rtl/spi_rx_io_pkg.sv
// Shared definitions for the SPI receive I/O block: FSM state type,
// status register bit positions and the per-frame byte limit.
package spi_io_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        RECEIVING = 2'd2,
        COMMIT    = 2'd3
    } rx_state_t;

    // Status register bit positions
    localparam int STAT_VALID    = 0;
    localparam int STAT_OVERRUN  = 1;
    localparam int STAT_LEN_LSB  = 2;
    localparam int STAT_TOO_LONG = 5;

    // Bytes carried per chip-select frame (shared with the transmitter)
    localparam int MAX_BYTES_PER_CS = 4;

endpackage

// File: rtl/spi_rx_io_if.sv
// Memory-bus read port of the SPI receive I/O block.
// master = CPU side, slave = peripheral side.
interface spi_rx_io_if;
    logic [31:0] mem_bus_addr;
    logic        mem_bus_read_en;
    logic [31:0] mem_bus_rx_data;
    logic        mem_bus_rx_data_write_en;

    modport master (
        output mem_bus_addr,
        output mem_bus_read_en,
        input  mem_bus_rx_data,
        input  mem_bus_rx_data_write_en
    );

    modport slave (
        input  mem_bus_addr,
        input  mem_bus_read_en,
        output mem_bus_rx_data,
        output mem_bus_rx_data_write_en
    );
endinterface

// File: rtl/spi_rx_io_sync_edge.sv
// Single-bit synchronizer (STAGES flops) followed by one history flop.
// Produces the synchronized level plus one-cycle rise/fall pulses.
// All flops reset to 0, so a high input is only reported once it has
// really propagated through the chain after reset.
module spi_rx_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_reg;
    logic              hist_reg;

    // Synchronizer chain and edge-detect history
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_reg <= '0;
            hist_reg  <= 1'b0;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], din};
            hist_reg  <= chain_reg[STAGES-1];
        end
    end

    assign sync = chain_reg[STAGES-1];
    assign rise = sync & ~hist_reg;
    assign fall = ~sync & hist_reg;

endmodule

// File: rtl/spi_rx_io.sv
// SPI slave receiver (mode 0, MSB-first, up to 4 bytes per CSn frame)
// with a memory-mapped data/status register pair.
// Optional feature macro: SPI_RX_IRQ_EN adds the registered o_irq output
// (valid | overrun); without it the CPU polls the status register.
module spi_rx_io
    import spi_io_pkg::*;
#(
    parameter logic [31:0] SPI_RX_DATA_ADDR   = 32'h80000010,
    parameter logic [31:0] SPI_RX_STATUS_ADDR = 32'h80000014,
    parameter int          SYNC_STAGES        = 2
) (
    input  logic          clk,
    input  logic          rst,
    spi_rx_io_if.slave    bus,
    input  logic          i_spi_sck,
    input  logic          i_spi_mosi,
    input  logic          i_spi_csn
`ifdef SPI_RX_IRQ_EN
    ,
    output logic          o_irq
`endif
);

    localparam int PIN_SCK  = 0;
    localparam int PIN_MOSI = 1;
    localparam int PIN_CSN  = 2;

    logic [2:0] pin_raw, pin_level, pin_rise, pin_fall;
    assign pin_raw = {i_spi_csn, i_spi_mosi, i_spi_sck};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            spi_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
                .clk  (clk),
                .rst  (rst),
                .din  (pin_raw[gi]),
                .sync (pin_level[gi]),
                .rise (pin_rise[gi]),
                .fall (pin_fall[gi])
            );
        end
    endgenerate

    // SCK falls, MOSI edges and the raw SCK level carry no information here
    logic unused_edges;
    assign unused_edges = ^{pin_level[PIN_SCK], pin_rise[PIN_MOSI],
                            pin_fall[PIN_SCK], pin_fall[PIN_MOSI]};

    logic csn_level, csn_rise, csn_fall, sck_rise, mosi_level;
    assign csn_level  = pin_level[PIN_CSN];
    assign csn_rise   = pin_rise[PIN_CSN];
    assign csn_fall   = pin_fall[PIN_CSN];
    assign sck_rise   = pin_rise[PIN_SCK];
    assign mosi_level = pin_level[PIN_MOSI];

    rx_state_t   state_reg;
    logic [6:0]  shift_reg;      // first 7 bits of the byte; the 8th comes straight from MOSI
    logic [2:0]  bit_cnt_reg;
    logic [2:0]  byte_cnt_reg;
    logic [31:0] asm_reg;        // word under assembly for the current frame
    logic [31:0] word_reg;       // word held for the CPU
    logic [2:0]  len_reg;
    logic        valid_reg;
    logic        overrun_reg;
    logic        too_long_reg;

    logic data_hit, status_hit, commit_ev;
    logic [7:0] byte_next;
    assign data_hit   = bus.mem_bus_read_en && (bus.mem_bus_addr == SPI_RX_DATA_ADDR);
    assign status_hit = bus.mem_bus_read_en && (bus.mem_bus_addr == SPI_RX_STATUS_ADDR);
    assign commit_ev  = (state_reg == COMMIT) && (byte_cnt_reg != 3'd0);
    assign byte_next  = {shift_reg, mosi_level};

    // Frame FSM, byte assembly and the CPU-facing holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= WAIT_IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            asm_reg      <= '0;
            word_reg     <= '0;
            len_reg      <= '0;
            valid_reg    <= 1'b0;
            overrun_reg  <= 1'b0;
            too_long_reg <= 1'b0;
        end else begin
            case (state_reg)
                WAIT_IDLE: begin
                    if (csn_level) state_reg <= IDLE;
                end
                IDLE: begin
                    if (csn_fall) begin
                        bit_cnt_reg  <= '0;
                        byte_cnt_reg <= '0;
                        too_long_reg <= 1'b0;
                        asm_reg      <= '0;
                        state_reg    <= RECEIVING;
                    end
                end
                RECEIVING: begin
                    if (csn_rise) begin
                        state_reg <= COMMIT;
                    end else if (sck_rise) begin
                        shift_reg   <= byte_next[6:0];
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            if (byte_cnt_reg < 3'(MAX_BYTES_PER_CS)) begin
                                asm_reg[byte_cnt_reg*8 +: 8] <= byte_next;
                                byte_cnt_reg <= byte_cnt_reg + 3'd1;
                            end else begin
                                too_long_reg <= 1'b1;
                            end
                        end
                    end
                end
                COMMIT: begin
                    state_reg <= IDLE;
                end
                default: state_reg <= WAIT_IDLE;
            endcase

            // A commit beats a same-cycle data read; otherwise the read consumes the word
            if (commit_ev) begin
                if (!valid_reg || data_hit) begin
                    word_reg  <= asm_reg;
                    len_reg   <= byte_cnt_reg;
                    valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (data_hit) begin
                valid_reg   <= 1'b0;
                overrun_reg <= 1'b0;
            end
        end
    end

`ifdef SPI_RX_IRQ_EN
    logic irq_reg;
    // Interrupt follows the held status one cycle later
    always_ff @(posedge clk) begin
        if (rst) irq_reg <= 1'b0;
        else     irq_reg <= valid_reg | overrun_reg;
    end
    assign o_irq = irq_reg;
`endif

    logic [31:0] status;
    // Status register image
    always_comb begin
        status = '0;
        status[STAT_VALID]          = valid_reg;
        status[STAT_OVERRUN]        = overrun_reg;
        status[STAT_LEN_LSB +: 3]   = len_reg;
        status[STAT_TOO_LONG]       = too_long_reg;
    end

    assign bus.mem_bus_rx_data_write_en = data_hit | status_hit;
    assign bus.mem_bus_rx_data = data_hit   ? word_reg :
                                 status_hit ? status   : 32'h0;

endmodule

// File: tb/tb_spi_rx_io.sv
// Self-checking bench for spi_rx_io: drives SPI mode-0 frames and bus reads,
// compares against a frame-level reference model.
// Build with SPI_RX_IRQ_EN defined to also check o_irq.
module tb_spi_rx_io;

    localparam logic [31:0] DATA_ADDR = 32'h80000010;
    localparam logic [31:0] STAT_ADDR = 32'h80000014;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, spi_sck, spi_mosi, spi_csn;
`ifdef SPI_RX_IRQ_EN
    logic irq;
`endif

    spi_rx_io_if bus_if ();

    spi_rx_io dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if.slave),
        .i_spi_sck  (spi_sck),
        .i_spi_mosi (spi_mosi),
        .i_spi_csn  (spi_csn)
`ifdef SPI_RX_IRQ_EN
        ,
        .o_irq      (irq)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] fbytes [0:7];

    // Reference model of the CPU-visible state
    logic [31:0] m_word;
    int          m_len;
    bit          m_valid, m_overrun, m_too_long;

    function automatic void model_reset();
        m_word = 0; m_len = 0; m_valid = 0; m_overrun = 0; m_too_long = 0;
    endfunction

    function automatic logic [31:0] exp_status();
        return 32'(m_valid) + 32'(m_overrun) * 2 + 32'(m_len) * 4 + 32'(m_too_long) * 32;
    endfunction

    // A completed frame of nbytes whole bytes (partial trailing bits ignored)
    function automatic void model_frame(input int nbytes, input bit read_same);
        int kept;
        logic [31:0] w;
        kept = (nbytes > 4) ? 4 : nbytes;
        w = 0;
        for (int i = 0; i < kept; i++) w = w + (32'(fbytes[i]) << (8 * i));
        m_too_long = (nbytes > 4);
        if (kept == 0) return;
        if (!m_valid || read_same) begin
            m_word = w; m_len = kept; m_valid = 1;
        end else begin
            m_overrun = 1;
        end
    endfunction

    function automatic void model_data_read();
        m_valid = 0; m_overrun = 0;
    endfunction

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic we);
        bus_if.mem_bus_addr    = a;
        bus_if.mem_bus_read_en = 1'b1;
        #1;
        d  = bus_if.mem_bus_rx_data;
        we = bus_if.mem_bus_rx_data_write_en;
        @(negedge clk);
        bus_if.mem_bus_read_en = 1'b0;
        bus_if.mem_bus_addr    = 32'h0;
        $display("read  addr=%h data=%h hit=%0d", a, d, we);
    endtask

    // Sends one CSn frame from fbytes; optional reset pulse during byte 2,
    // optional data read placed in the cycle the commit happens.
    task automatic send_frame(input int nbytes, input int xbits, input int half,
                              input bit rst_mid, input bit collide, input int tail,
                              output logic [31:0] coll_data);
        coll_data = 0;
        $display("frame %0d bytes + %0d bits, half=%0d", nbytes, xbits, half);
        spi_csn = 1'b0;
        repeat (half) @(negedge clk);
        for (int b = 0; b < nbytes * 8 + xbits; b++) begin
            logic [7:0] cur;
            cur = fbytes[b / 8];
            spi_mosi = cur[7 - (b % 8)];
            repeat (half) @(negedge clk);
            spi_sck = 1'b1;
            if (rst_mid && b == 12) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                repeat (half - 1) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
            spi_sck = 1'b0;
        end
        repeat (half) @(negedge clk);
        spi_csn = 1'b1;
        if (collide) begin
            logic we;
            repeat (3) @(negedge clk);
            bus_read(DATA_ADDR, coll_data, we);
        end
        repeat (tail) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic we;
        rst = 1'b1; spi_csn = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        bus_if.mem_bus_addr = 32'h0; bus_if.mem_bus_read_en = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (bus_if.mem_bus_rx_data_write_en !== 1'b0 || bus_if.mem_bus_rx_data !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_idle_bus: got we=%b data=%h expected we=0 data=0",
                     bus_if.mem_bus_rx_data_write_en, bus_if.mem_bus_rx_data);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        model_reset();
        bus_read(STAT_ADDR, d, we);
        n_checks++;
        if (d !== 32'h0 || we !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_status: got %h we=%b expected 00000000 we=1", d, we);
        end
        bus_read(DATA_ADDR, d, we);
        n_checks++;
        if (d !== 32'h0 || we !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_data: got %h we=%b expected 00000000 we=1", d, we);
        end
        bus_read(32'h80000018, d, we);
        n_checks++;
        if (d !== 32'h0 || we !== 1'b0) begin
            n_errors++;
            $display("FAIL addr_miss: got %h we=%b expected 00000000 we=0", d, we);
        end
    endtask

    task automatic test_four_byte();
        logic [31:0] d, cd;
        logic we;
        bit found;
        logic irq_at, irq_next;
        found = 0; irq_at = 0; irq_next = 0;
        fbytes[0] = 8'hA5; fbytes[1] = 8'h3C; fbytes[2] = 8'h0F; fbytes[3] = 8'hF0;
        send_frame(4, 0, 5, 0, 0, 0, cd);
        model_frame(4, 0);
        bus_if.mem_bus_addr = STAT_ADDR;
        bus_if.mem_bus_read_en = 1'b1;
        for (int k = 0; k < 40 && !found; k++) begin
            #1;
            if (bus_if.mem_bus_rx_data[0]) begin
                found = 1;
`ifdef SPI_RX_IRQ_EN
                irq_at = irq;
`endif
            end
            @(negedge clk);
`ifdef SPI_RX_IRQ_EN
            if (found) irq_next = irq;
`endif
        end
        bus_if.mem_bus_read_en = 1'b0;
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL commit_timeout: got valid=0 within 40 cycles expected valid=1");
        end
`ifdef SPI_RX_IRQ_EN
        n_checks++;
        if (irq_at !== 1'b0 || irq_next !== 1'b1) begin
            n_errors++;
            $display("FAIL irq_timing: got irq=%b then %b expected 0 then 1", irq_at, irq_next);
        end
`endif
        repeat (5) @(negedge clk);
        bus_read(STAT_ADDR, d, we);
        n_checks++;
        if (d !== exp_status()) begin
            n_errors++;
            $display("FAIL status_4byte: got %h expected %h", d, exp_status());
        end
        bus_read(DATA_ADDR, d, we);
        model_data_read();
        n_checks++;
        if (d !== 32'hF00F3CA5) begin
            n_errors++;
            $display("FAIL data_4byte: got %h expected f00f3ca5", d);
        end
        bus_read(STAT_ADDR, d, we);
        n_checks++;
        if (d !== exp_status() || d[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL status_after_read: got %h expected %h", d, exp_status());
        end
    endtask

    task automatic test_short();
        logic [31:0] d, cd;
        logic we;
        fbytes[0] = 8'h81;
        send_frame(1, 0, 5, 0, 0, 12, cd);
        model_frame(1, 0);
        bus_read(STAT_ADDR, d, we);
        n_checks++;
        if (d !== exp_status()) begin
            n_errors++;
            $display("FAIL status_1byte: got %h expected %h", d, exp_status());
        end
        bus_read(DATA_ADDR, d, we);
        model_data_read();
        n_checks++;
        if (d !== 32'h00000081) begin
            n_errors++;
            $display("FAIL data_1byte: got %h expected 00000081", d);
        end
        fbytes[0] = 8'($urandom);
        send_frame(0, 3, 5, 0, 0, 12, cd);
        model_frame(0, 0);
        bus_read(STAT_ADDR, d, we);
        n_checks++;
        if (d !== exp_status() || d[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL partial_no_commit: got %h expected %h", d, exp_status());
        end
    endtask

    task automatic test_overrun();
        logic [31:0] d, cd;
        logic we;
        fbytes[0] = 8'h11;
        send_frame(1, 0, 5, 0, 0, 12, cd);
        model_frame(1, 0);
        fbytes[0] = 8'h22;
        send_frame(1, 0, 5, 0, 0, 12, cd);
        model_frame(1, 0);
        bus_read(STAT_ADDR, d, we);
        n_checks++;
        if (d !== exp_status() || d[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL status_overrun: got %h expected %h", d, exp_status());
        end
        bus_read(DATA_ADDR, d, we);
        model_data_read();
        n_checks++;
        if (d !== 32'h00000011) begin
            n_errors++;
            $display("FAIL data_overrun: got %h expected 00000011", d);
        end
        bus_read(STAT_ADDR, d, we);
        n_checks++;
        if (d !== exp_status() || d[1:0] !== 2'b00) begin
            n_errors++;
            $display("FAIL overrun_cleared: got %h expected %h", d, exp_status());
        end
    endtask

    task automatic test_too_long();
        logic [31:0] d, cd;
        logic we;
        for (int i = 0; i < 6; i++) fbytes[i] = 8'(i + 1);
        send_frame(6, 0, 5, 0, 0, 12, cd);
        model_frame(6, 0);
        bus_read(STAT_ADDR, d, we);
        n_checks++;
        if (d !== exp_status() || d !== 32'h00000031) begin
            n_errors++;
            $display("FAIL status_too_long: got %h expected %h", d, exp_status());
        end
        bus_read(DATA_ADDR, d, we);
        model_data_read();
        n_checks++;
        if (d !== 32'h04030201) begin
            n_errors++;
            $display("FAIL data_too_long: got %h expected 04030201", d);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d, cd;
        logic we;
        for (int i = 0; i < 4; i++) fbytes[i] = 8'($urandom);
        send_frame(4, 0, 5, 1, 0, 12, cd);
        model_reset();
        bus_read(STAT_ADDR, d, we);
        n_checks++;
        if (d !== exp_status()) begin
            n_errors++;
            $display("FAIL reset_mid_no_commit: got %h expected %h", d, exp_status());
        end
        fbytes[0] = 8'hEF; fbytes[1] = 8'hBE; fbytes[2] = 8'hAD; fbytes[3] = 8'hDE;
        send_frame(4, 0, 5, 0, 0, 12, cd);
        model_frame(4, 0);
        bus_read(STAT_ADDR, d, we);
        n_checks++;
        if (d !== exp_status()) begin
            n_errors++;
            $display("FAIL status_after_reset: got %h expected %h", d, exp_status());
        end
        bus_read(DATA_ADDR, d, we);
        model_data_read();
        n_checks++;
        if (d !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL data_after_reset: got %h expected deadbeef", d);
        end
    endtask

    task automatic test_commit_collision();
        logic [31:0] d, cd, old_word;
        logic we;
        fbytes[0] = 8'($urandom); fbytes[1] = 8'($urandom);
        send_frame(2, 0, 5, 0, 0, 12, cd);
        model_frame(2, 0);
        old_word = m_word;
        for (int i = 0; i < 3; i++) fbytes[i] = 8'($urandom);
        send_frame(3, 0, 5, 0, 1, 12, cd);
        model_frame(3, 1);
        n_checks++;
        if (cd !== old_word) begin
            n_errors++;
            $display("FAIL collide_read_data: got %h expected %h", cd, old_word);
        end
        bus_read(STAT_ADDR, d, we);
        n_checks++;
        if (d !== exp_status() || d[1:0] !== 2'b01) begin
            n_errors++;
            $display("FAIL collide_status: got %h expected %h", d, exp_status());
        end
        bus_read(DATA_ADDR, d, we);
        n_checks++;
        if (d !== m_word) begin
            n_errors++;
            $display("FAIL collide_new_word: got %h expected %h", d, m_word);
        end
        model_data_read();
    endtask

    task automatic test_random();
        logic [31:0] d, cd;
        logic we;
        int nb, xb, hf;
        for (int it = 0; it < 16; it++) begin
            nb = $urandom_range(0, 6);
            xb = $urandom_range(0, 7);
            hf = $urandom_range(3, 7);
            for (int i = 0; i < 8; i++) fbytes[i] = 8'($urandom);
            send_frame(nb, xb, hf, 0, 0, 12, cd);
            model_frame(nb, 0);
            if ($urandom_range(0, 1) == 1) begin
                bus_read(STAT_ADDR, d, we);
                n_checks++;
                if (d !== exp_status()) begin
                    n_errors++;
                    $display("FAIL rand_status[%0d]: got %h expected %h", it, d, exp_status());
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                bus_read(DATA_ADDR, d, we);
                n_checks++;
                if (d !== m_word) begin
                    n_errors++;
                    $display("FAIL rand_data[%0d]: got %h expected %h", it, d, m_word);
                end
                model_data_read();
            end
        end
        bus_read(STAT_ADDR, d, we);
        n_checks++;
        if (d !== exp_status()) begin
            n_errors++;
            $display("FAIL rand_final_status: got %h expected %h", d, exp_status());
        end
`ifdef SPI_RX_IRQ_EN
        @(negedge clk);
        n_checks++;
        if (irq !== (m_valid | m_overrun)) begin
            n_errors++;
            $display("FAIL irq_level: got %b expected %b", irq, m_valid | m_overrun);
        end
`endif
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_four_byte();
        test_short();
        test_overrun();
        test_too_long();
        test_reset_mid_frame();
        test_commit_collision();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
